sevseg_scan_ctrl: RTL and testbench
===================================

# sevseg_scan_ctrl

Time-multiplexing scan controller for the multi-digit seven-segment display on the button/display test board. It holds one 4-bit hex value and a decimal point per digit, and steps the 3-bit digit select that drives the 3-to-8 digit-enable decoder. It encodes the selected digit to segment patterns and inserts a blanking gap between digits to suppress ghosting. Host logic (ATM keypad/menu FSM) writes digit contents through a simple write port; the controller owns all display sequencing.

## Interface
- `NUM_DIGITS`, default 8: digits scanned, legal 1..8.
- `CLK_DIV`, default 50000: SHOW cycles per digit, legal ≥1.
- `BLANK_CYCLES`, default 500: blanking cycles before each digit, legal ≥1.

Ports (clock and reset first):
- `clk` in 1: single system clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe, one digit per cycle.
- `wr_addr` in 3: digit index to write.
- `wr_data` in 4: hex value 0x0–0xF.
- `wr_dp` in 1: decimal point for that digit.
- `digit_on` in 8: per-digit enable mask, bit i = digit i; sampled live.
- `sel` out 3: digit select to decoder inputs (sel[2]=a, sel[1]=b, sel[0]=c).
- `dig_en` out 1: global gate for decoder outputs; 1 = selected digit lit.
- `seg` out 7: active-high segments, seg[0]=a … seg[6]=g.
- `dp` out 1: active-high decimal point.
- `frame_done` out 1: one-cycle pulse when a full scan completes.

## Operation
- Storage: NUM_DIGITS × 5-bit register file {dp, hex}. Reset clears all entries to 0.
- Writes:
  - With `wr_en`=1, the entry at `wr_addr` is updated at the clock edge.
  - Writes with `wr_addr` ≥ NUM_DIGITS are ignored.
  - No back-pressure; writes are accepted in every state.
- States:
  - BLANK: `dig_en`=0, `seg`=0, `dp`=0. Runs BLANK_CYCLES cycles, then goes to SHOW.
  - SHOW: `seg`/`dp` = encoded entry[`sel`]. `dig_en` = `digit_on[sel]`. Runs CLK_DIV cycles. Then `sel` advances and the FSM returns to BLANK.
- Advance and wrap:
  - `sel` advances as `sel` = (`sel` == NUM_DIGITS-1) ? 0 : `sel`+1.
  - With NUM_DIGITS=1, `sel` stays 0.
- Masked digit (`digit_on[sel]`=0): the SHOW timing is unchanged, but `dig_en`=0 and `seg`=0, `dp`=0.
- Hex encoding (seg[6:0]):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Counter: one down/up counter, width sized to max(CLK_DIV, BLANK_CYCLES). It is reloaded on every state change.
- All outputs are registered.

## Timing
- Reset values: `sel`=0, `dig_en`=0, `seg`=0, `dp`=0, `frame_done`=0; FSM in BLANK with counter cleared.
- Reset mid-scan: at the next edge with `rst`=1, all of the above are restored regardless of state. Register file is cleared. A write in the same cycle as `rst` is dropped.
- Let edge 0 be the first edge with `rst`=0. Per-digit period P = BLANK_CYCLES + CLK_DIV.
  - `dig_en` is 1 from edge BLANK_CYCLES through edge P-1.
  - At edge P, `sel`=1 and `dig_en`=0.
- Frame period: NUM_DIGITS × P cycles.
- `frame_done`: high for exactly the one cycle following the edge where `sel` wraps to 0 (registered with `sel`). It is not asserted at reset release.
- Write latency: a write to the currently shown digit during SHOW appears on `seg`/`dp` one cycle after the write edge.
- Simultaneous events:
  - A write to digit k in the same cycle `sel` advances to k is visible in k's SHOW phase.
  - A `digit_on` change is reflected on `dig_en` one cycle later.
- `sel` changes only while `dig_en`=0, so there is no overlap between digits.

## Test plan
Common setup: NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=2, `digit_on`=0xFF.

1. Reset: hold `rst` 3 cycles mid-SHOW → next cycle `sel`=0, `dig_en`=0, `seg`=0, `dp`=0, `frame_done`=0; after release, `dig_en` rises at edge 2.
2. Scan order: write digits 0..3 = {1,2,3,4}, dp=0 → the sequence is seg 06,5B,4F,66.
   - Each digit has `dig_en`=1 for 4 cycles after a 2-cycle gap.
   - `sel` steps 0,1,2,3,0.
   - `frame_done` pulses once every 24 cycles.
3. Full encoding: write values 0x0–0xF to digit 0 with dp=1, one per frame → each SHOW phase matches the hex table and `dp`=1.
4. Out-of-range and live writes:
   - Write addr 5 = 0xE → no change in any digit.
   - Write digit 2 = 0xA mid-SHOW of digit 2 → `seg`=77 on the next cycle.
5. Mask: `digit_on`=0x05 → digits 1 and 3 keep their 6-cycle slot with `dig_en`=0 and `seg`=0. Period is still 24 cycles.
6. Wrap and edge parameters: NUM_DIGITS=1 → `sel` is constantly 0 and `frame_done` pulses every 6 cycles. Writing `wr_addr`=0 with 8 updates `seg` to 7F.

Source files
------------

// File: rtl/sevseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sevseg_scan_ctrl
//
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Holds a {dp, hex} entry per digit, walks the 3-bit digit select that feeds
// the 3-to-8 digit-enable decoder, and puts a blanking gap in front of every
// digit so that the previous digit's segments never ghost onto the next one.
//
// Parameters:
//   NUM_DIGITS    digits scanned, 1..8
//   CLK_DIV       cycles each digit is shown, >= 1
//   BLANK_CYCLES  dark cycles before each digit, >= 1
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   wr_en       write strobe, one digit per cycle
//   wr_addr     digit index to write (indices >= NUM_DIGITS are ignored)
//   wr_data     hex value for that digit
//   wr_dp       decimal point for that digit
//   digit_on    per-digit enable mask, sampled live
//   sel         digit select to the decoder (sel[2]=a, sel[1]=b, sel[0]=c)
//   dig_en      decoder output gate, 1 = selected digit lit
//   seg         active-high segments, seg[0]=a .. seg[6]=g
//   dp          active-high decimal point
//   frame_done  one-cycle pulse after sel wraps back to digit 0
// -----------------------------------------------------------------------------
module sevseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic [7:0] digit_on,
    output logic [2:0] sel,
    output logic       dig_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    // One shared counter covers both phases, so it is sized for the longer.
    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] SHOW_END  = CNT_W'(CLK_DIV);
    localparam logic [2:0]       LAST_SEL  = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]       NUM_DIG_L = 4'(NUM_DIGITS);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    typedef struct packed {
        logic       dp;
        logic [3:0] hex;
    } entry_t;

    // Hex digit to active-high segment pattern, seg[0]=a .. seg[6]=g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            sel_q, sel_d;
    logic                  dig_en_q, dig_en_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;
    // Eight slots so the 3-bit select indexes exactly; slots at or above
    // NUM_DIGITS are never written and stay zero.
    entry_t [7:0]          rf_q, rf_d;

    entry_t                cur_entry;
    logic                  lit;

    // -------------------------------------------------------------------------
    // Scan sequencing
    //
    // cnt counts cycles already spent in the current state; reset leaves it
    // at 0 and every state change reloads it to 1. That makes the first blank
    // after reset release end at the same edge offset as every later blank.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        sel_d        = sel_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_END) begin
                    state_d = ST_SHOW;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_END) begin
                    state_d = ST_BLANK;
                    cnt_d   = CNT_ONE;
                    // sel only moves on the SHOW->BLANK edge, so it never
                    // changes while a digit is lit.
                    if (sel_q == LAST_SEL) begin
                        sel_d        = 3'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = CNT_ONE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Register file writes; no back-pressure, accepted in every state.
    // -------------------------------------------------------------------------
    always_comb begin
        rf_d = rf_q;
        if (wr_en && ({1'b0, wr_addr} < NUM_DIG_L)) begin
            rf_d[wr_addr] = '{dp: wr_dp, hex: wr_data};
        end
    end

    // -------------------------------------------------------------------------
    // Output encode. Outputs are registered from the next state, so a write
    // to the shown digit is seen from the stored copy one edge later, and a
    // digit_on change shows up on dig_en after the edge that samples it.
    // -------------------------------------------------------------------------
    always_comb begin
        cur_entry = rf_q[sel_d];
        lit       = (state_d == ST_SHOW) && digit_on[sel_d];
        dig_en_d  = lit;
        seg_d     = lit ? hex_to_seg(cur_entry.hex) : 7'h00;
        dp_d      = lit & cur_entry.dp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            sel_q        <= 3'd0;
            dig_en_q     <= 1'b0;
            seg_q        <= 7'h00;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
            rf_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            dig_en_q     <= dig_en_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            rf_q         <= rf_d;
        end
    end

    assign sel        = sel_q;
    assign dig_en     = dig_en_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for sevseg_scan_ctrl. Two instances share one stimulus stream:
// a 4-digit scanner and a 1-digit scanner, both CLK_DIV=4, BLANK_CYCLES=2.
// A cycle-position model (edge index -> digit, phase) predicts every output
// on every cycle; directed checks pin a few hand-computed values.
// -----------------------------------------------------------------------------
module tb_sevseg_scan_ctrl;

    localparam int C = 4;
    localparam int B = 2;
    localparam int P = B + C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_dp = 1'b0;
    logic [7:0] digit_on = 8'hFF;

    logic [2:0] sel_a, sel_b;
    logic       en_a, en_b, dp_a, dp_b, fd_a, fd_b;
    logic [6:0] seg_a, seg_b;

    sevseg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(C), .BLANK_CYCLES(B)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .digit_on(digit_on), .sel(sel_a), .dig_en(en_a),
        .seg(seg_a), .dp(dp_a), .frame_done(fd_a));

    sevseg_scan_ctrl #(.NUM_DIGITS(1), .CLK_DIV(C), .BLANK_CYCLES(B)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .digit_on(digit_on), .sel(sel_b), .dig_en(en_b),
        .seg(seg_b), .dp(dp_b), .frame_done(fd_b));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [6:0] spec_seg(input logic [3:0] h);
        logic [6:0] tab [16];
        tab[0]  = 7'h3F; tab[1]  = 7'h06; tab[2]  = 7'h5B; tab[3]  = 7'h4F;
        tab[4]  = 7'h66; tab[5]  = 7'h6D; tab[6]  = 7'h7D; tab[7]  = 7'h07;
        tab[8]  = 7'h7F; tab[9]  = 7'h6F; tab[10] = 7'h77; tab[11] = 7'h7C;
        tab[12] = 7'h39; tab[13] = 7'h5E; tab[14] = 7'h79; tab[15] = 7'h71;
        return tab[h];
    endfunction

    // ---------------------------------------------------------------- model
    int         nd [2] = '{4, 1};
    int         e_idx [2] = '{-1, -1};   // index of the last edge since release
    logic [4:0] rf_m [2][8];
    logic [2:0] x_sel [2];
    logic       x_en [2], x_dp [2], x_fd [2];
    logic [6:0] x_seg [2];
    bit         mvalid = 1'b0;

    always @(posedge clk) begin : model
        int ee, d, ph;
        logic lt;
        logic [4:0] ent;
        mvalid <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                e_idx[i] <= -1;
                x_sel[i] <= 3'd0; x_en[i] <= 1'b0; x_seg[i] <= 7'h00;
                x_dp[i]  <= 1'b0; x_fd[i] <= 1'b0;
                for (int j = 0; j < 8; j++) rf_m[i][j] <= 5'd0;
            end else begin
                ee  = e_idx[i] + 1;
                d   = (ee / P) % nd[i];
                ph  = ee % P;
                ent = rf_m[i][d];
                lt  = (ph >= B) && digit_on[d];
                x_sel[i] <= 3'(d);
                x_en[i]  <= lt;
                x_seg[i] <= lt ? spec_seg(ent[3:0]) : 7'h00;
                x_dp[i]  <= lt & ent[4];
                x_fd[i]  <= (ee > 0) && (ee % (nd[i] * P) == 0);
                if (wr_en && int'(wr_addr) < nd[i]) rf_m[i][wr_addr] <= {wr_dp, wr_data};
                e_idx[i] <= ee;
            end
        end
    end

    // -------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if (sel_a !== x_sel[0] || en_a !== x_en[0] || seg_a !== x_seg[0] ||
                dp_a !== x_dp[0] || fd_a !== x_fd[0]) begin
                errors++;
                $display("FAIL cycle dut4 e=%0d got sel=%0d en=%b seg=%h dp=%b fd=%b want sel=%0d en=%b seg=%h dp=%b fd=%b",
                         e_idx[0], sel_a, en_a, seg_a, dp_a, fd_a,
                         x_sel[0], x_en[0], x_seg[0], x_dp[0], x_fd[0]);
            end
            checks++;
            if (sel_b !== x_sel[1] || en_b !== x_en[1] || seg_b !== x_seg[1] ||
                dp_b !== x_dp[1] || fd_b !== x_fd[1]) begin
                errors++;
                $display("FAIL cycle dut1 e=%0d got sel=%0d en=%b seg=%h dp=%b fd=%b want sel=%0d en=%b seg=%h dp=%b fd=%b",
                         e_idx[1], sel_b, en_b, seg_b, dp_b, fd_b,
                         x_sel[1], x_en[1], x_seg[1], x_dp[1], x_fd[1]);
            end
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wr(input int a, input int v, input bit p);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'(v); wr_dp = p;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_until(input int x);
        int n = 0;
        while (e_idx[0] != x && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL timeout waiting for edge %0d got=%0d", x, e_idx[0]);
        end
    endtask

    task automatic wait_mod(input int m, input int r);
        int n = 0;
        while (!(e_idx[0] >= 0 && e_idx[0] % m == r) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL timeout waiting for phase %0d mod %0d", r, m);
        end
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        wr(0, 9, 1'b1);                 // dropped: rst is high
        @(negedge clk);
        chk("reset_sel", sel_a, 0);
        chk("reset_en", en_a, 0);
        chk("reset_seg", seg_a, 0);
        chk("reset_fd", fd_a, 0);
        rst = 1'b0;

        wait_until(1);  chk("blank_e1_en", en_a, 0);
        wait_until(2);  chk("show_e2_en", en_a, 1);
        chk("drop_write_seg", seg_a, 7'h3F);
        chk("drop_write_dp", dp_a, 0);

        // scan order
        wr(0, 1, 1'b0); wr(1, 2, 1'b0); wr(2, 3, 1'b0); wr(3, 4, 1'b0);
        wait_until(24); chk("frame_done_24", fd_a, 1); chk("wrap_sel", sel_a, 0);
        chk("frame_done_n1", fd_b, 1);
        wait_until(25); chk("frame_done_25", fd_a, 0);
        wait_until(26); chk("digit0_seg", seg_a, 7'h06); chk("n1_seg", seg_b, 7'h06);
        wait_until(30); chk("sel1_sel", sel_a, 1); chk("sel1_blank", en_a, 0);
        wait_until(32); chk("digit1_seg", seg_a, 7'h5B);
        wait_until(38); chk("digit2_seg", seg_a, 7'h4F);
        wait_until(44); chk("digit3_seg", seg_a, 7'h66);

        // full encoding, one value per frame on digit 0
        for (int v = 0; v < 16; v++) begin
            wr(0, v, 1'b1);
            repeat (23) @(negedge clk);
        end

        // out-of-range write, then a live write into the shown digit
        wr(5, 4'hE, 1'b0);
        wait_mod(24, 15);
        wr(2, 4'hA, 1'b0);
        chk("live_write_old", seg_a, 7'h4F);
        @(negedge clk);
        chk("live_write_new", seg_a, 7'h77);
        wait_mod(24, 2);
        chk("digit0_F_seg", seg_a, 7'h71);
        chk("digit0_F_dp", dp_a, 1);

        // mask
        digit_on = 8'h05;
        wait_mod(24, 8);
        chk("mask_d1_en", en_a, 0);
        chk("mask_d1_seg", seg_a, 0);
        repeat (48) @(negedge clk);
        digit_on = 8'hFF;

        // single-digit instance and value 8
        wr(0, 8, 1'b0);
        repeat (2) @(negedge clk);
        wait_mod(24, 3);
        chk("n1_seg_8", seg_b, 7'h7F);
        chk("n1_sel", sel_b, 0);
        chk("n4_seg_8", seg_a, 7'h7F);

        // reset mid-SHOW with a write that must be dropped
        wait_mod(24, 9);
        rst = 1'b1;
        wr(1, 5, 1'b1);
        repeat (2) @(negedge clk);
        chk("midrst_sel", sel_a, 0);
        chk("midrst_en", en_a, 0);
        chk("midrst_seg", seg_a, 0);
        chk("midrst_dp", dp_a, 0);
        chk("midrst_fd", fd_a, 0);
        rst = 1'b0;
        wait_until(1); chk("midrst_e1_en", en_a, 0);
        wait_until(2); chk("midrst_e2_en", en_a, 1); chk("midrst_cleared", seg_a, 7'h3F);
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
